// File: rtl/flow_route_sequencer.sv
// Routes one source chain through its junction4 switches to a device branch or the merge,
// then drains it. Optional abort input is enabled by defining FLOW_ROUTE_ABORT_EN.
module flow_route_sequencer #(
   parameter int CHANNELS = 2,
   parameter int STAGES   = 9,
   parameter int DWELL_W  = 16,
   parameter int SETTLE   = 4,
   localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int STAGE_W = $clog2(STAGES + 1),
   localparam int SW_W    = 2 * CHANNELS * STAGES
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef FLOW_ROUTE_ABORT_EN
   input  logic                abort,
`endif
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [CHAN_W-1:0]   req_chan,
   input  logic [STAGE_W-1:0]  req_stage,
   input  logic                req_port,
   input  logic [DWELL_W-1:0]  req_dwell,
   output logic [SW_W-1:0]     sw_sel,
   output logic [CHANNELS-1:0] merge_sel,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [2:0]          dbg_state
);

   localparam int CNT_W = (DWELL_W > 4) ? DWELL_W : 4;

   // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
   // req_ready is high only in IDLE, and requests seen at any other time are dropped.
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PRIME = 3'd1,
      S_DWELL = 3'd2,
      S_DRAIN = 3'd3,
      S_DONE  = 3'd4
   } state_e;

   state_e                state_q;
   logic [SW_W-1:0]       sw_sel_q;
   logic [CHANNELS-1:0]   merge_q;
   logic                  done_q;
   logic                  err_q;
   logic                  ready_q;
   logic                  aborted_q;
   logic [CNT_W-1:0]      cnt_q;
   logic [CHAN_W-1:0]     chan_q;
   logic [STAGE_W-1:0]    stage_q;
   logic                  port_q;
   logic [DWELL_W-1:0]    dwell_q;
   logic                  abort_w;
   logic                  req_bad;

`ifdef FLOW_ROUTE_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   assign req_bad = (int'(req_chan) >= CHANNELS) || (int'(req_stage) > STAGES);

   // Upstream switches pass downstream; the target opens its device branch unless draining.
   function automatic logic [SW_W-1:0] route_codes(input logic [CHAN_W-1:0]  c,
                                                   input logic [STAGE_W-1:0] st,
                                                   input logic               p,
                                                   input logic               upstream_only);
      logic [SW_W-1:0] v;
      v = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         for (int s = 0; s < STAGES; s++) begin
            if (int'(c) == ch) begin
               if (s < int'(st)) begin
                  v[2*(ch*STAGES+s) +: 2] = 2'b11;
               end else if ((s == int'(st)) && !upstream_only) begin
                  v[2*(ch*STAGES+s) +: 2] = p ? 2'b10 : 2'b01;
               end
            end
         end
      end
      return v;
   endfunction

   function automatic logic [CHANNELS-1:0] merge_code(input logic [CHAN_W-1:0]  c,
                                                      input logic [STAGE_W-1:0] st);
      logic [CHANNELS-1:0] m;
      m = '0;
      for (int ch = 0; ch < CHANNELS; ch++) begin
         if ((int'(c) == ch) && (int'(st) == STAGES)) m[ch] = 1'b1;
      end
      return m;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         sw_sel_q  <= '0;
         merge_q   <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         ready_q   <= 1'b0;
         aborted_q <= 1'b0;
         cnt_q     <= '0;
         chan_q    <= '0;
         stage_q   <= '0;
         port_q    <= 1'b0;
         dwell_q   <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               ready_q <= 1'b1;
               if (req_valid && ready_q) begin
                  if (req_bad) begin
                     err_q <= 1'b1;
                  end else begin
                     chan_q    <= req_chan;
                     stage_q   <= req_stage;
                     port_q    <= req_port;
                     dwell_q   <= (req_dwell == '0) ? DWELL_W'(1) : req_dwell;
                     sw_sel_q  <= route_codes(req_chan, req_stage, req_port, 1'b0);
                     merge_q   <= merge_code(req_chan, req_stage);
                     cnt_q     <= CNT_W'(SETTLE);
                     aborted_q <= 1'b0;
                     ready_q   <= 1'b0;
                     state_q   <= S_PRIME;
                  end
               end
            end
            S_PRIME: begin
               if (abort_w) begin
                  aborted_q <= 1'b1;
                  sw_sel_q  <= route_codes(chan_q, stage_q, port_q, 1'b1);
                  merge_q   <= '0;
                  cnt_q     <= CNT_W'(SETTLE);
                  state_q   <= S_DRAIN;
               end else if (cnt_q == CNT_W'(1)) begin
                  cnt_q   <= CNT_W'(dwell_q);
                  state_q <= S_DWELL;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DWELL: begin
               // Down-count from the latched dwell; reloads on entry so it never wraps.
               if (abort_w || (cnt_q == CNT_W'(1))) begin
                  aborted_q <= abort_w;
                  sw_sel_q  <= route_codes(chan_q, stage_q, port_q, 1'b1);
                  merge_q   <= '0;
                  cnt_q     <= CNT_W'(SETTLE);
                  state_q   <= S_DRAIN;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DRAIN: begin
               // SETTLE cycles with upstream still passing, then one all-closed cycle.
               if (cnt_q == '0) begin
                  done_q  <= 1'b1;
                  err_q   <= aborted_q;
                  state_q <= S_DONE;
               end else begin
                  if (cnt_q == CNT_W'(1)) sw_sel_q <= '0;
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            S_DONE: begin
               ready_q <= 1'b1;
               cnt_q   <= '0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready = ready_q & rst_n;
   assign sw_sel    = sw_sel_q;
   assign merge_sel = merge_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_flow_route_sequencer.sv
// Randomised bench for flow_route_sequencer: a timeline model of each route predicts every
// output cycle by cycle; directed cases cover latency, merge routing, rejects and reset.
module tb_flow_route_sequencer;

   localparam int CHANNELS = 2;
   localparam int STAGES   = 9;
   localparam int DWELL_W  = 16;
   localparam int SETTLE   = 4;
   localparam int CHAN_W   = 1;
   localparam int STAGE_W  = 4;
   localparam int SW_W     = 2 * CHANNELS * STAGES;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                abort_drv;
   logic                req_valid;
   logic                req_ready;
   logic [CHAN_W-1:0]   req_chan;
   logic [STAGE_W-1:0]  req_stage;
   logic                req_port;
   logic [DWELL_W-1:0]  req_dwell;
   logic [SW_W-1:0]     sw_sel;
   logic [CHANNELS-1:0] merge_sel;
   logic                busy;
   logic                done;
   logic                err;
   logic [2:0]          dbg_state;

   always #5 clk = ~clk;

   flow_route_sequencer #(
      .CHANNELS(CHANNELS), .STAGES(STAGES), .DWELL_W(DWELL_W), .SETTLE(SETTLE)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
`ifdef FLOW_ROUTE_ABORT_EN
      .abort     (abort_drv),
`endif
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_chan  (req_chan),
      .req_stage (req_stage),
      .req_port  (req_port),
      .req_dwell (req_dwell),
      .sw_sel    (sw_sel),
      .merge_sel (merge_sel),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .dbg_state (dbg_state)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Route timeline model: t counts cycles since the accept; drain_at is the first DRAIN cycle.
   bit          m_active    = 1'b0;
   bit          m_ready_reg = 1'b0;
   bit          m_err_now   = 1'b0;
   bit          m_aborted   = 1'b0;
   bit          m_port      = 1'b0;
   int          m_t = 0, m_drain = 0, m_chan = 0, m_stage = 0, m_dwell = 0;
   int          m_acc_cyc = 0;
   int          cyc = 0;
   bit          last_done = 1'b0;
   logic [31:0] exp_q[$];

   function automatic logic [SW_W-1:0] exp_codes(input int chan, input int stage,
                                                 input bit port, input bit target);
      logic [SW_W-1:0] v;
      int idx;
      v = '0;
      for (int s = 0; s < STAGES; s++) begin
         idx = chan * STAGES * 2 + 2 * s;
         if (s < stage) begin
            v[idx]   = 1'b1;
            v[idx+1] = 1'b1;
         end else if (s == stage && target) begin
            v[idx + (port ? 1 : 0)] = 1'b1;
         end
      end
      return v;
   endfunction

   task automatic model_edge();
      if (!rst_n) begin
         m_active    = 1'b0;
         m_ready_reg = 1'b0;
         m_err_now   = 1'b0;
         exp_q.delete();
      end else begin
         m_err_now = 1'b0;
         if (m_active) begin
            if (abort_drv && m_t < m_drain) begin
               m_drain   = m_t + 1;
               m_aborted = 1'b1;
               if (exp_q.size() > 0) exp_q[exp_q.size()-1] = 32'(m_drain + SETTLE + 1);
            end
            m_t++;
            if (m_t > m_drain + SETTLE + 1) m_active = 1'b0;
         end else if (req_valid && m_ready_reg) begin
            if (int'(req_chan) >= CHANNELS || int'(req_stage) > STAGES) begin
               m_err_now = 1'b1;
            end else begin
               m_active  = 1'b1;
               m_chan    = int'(req_chan);
               m_stage   = int'(req_stage);
               m_port    = req_port;
               m_dwell   = (req_dwell == 0) ? 1 : int'(req_dwell);
               m_t       = 1;
               m_drain   = SETTLE + m_dwell + 1;
               m_aborted = 1'b0;
               m_acc_cyc = cyc;
               exp_q.push_back(32'(2 * SETTLE + m_dwell + 2));
            end
         end
         m_ready_reg = !m_active;
      end
   endtask

   task automatic step();
      logic [SW_W-1:0]     e_sw;
      logic [CHANNELS-1:0] e_m;
      bit e_busy, e_done, e_err;
      @(negedge clk);
      e_sw   = '0;
      e_m    = '0;
      e_busy = m_active;
      e_done = 1'b0;
      e_err  = m_err_now;
      if (m_active) begin
         if (m_t < m_drain) begin
            e_sw = exp_codes(m_chan, m_stage, m_port, 1'b1);
            if (m_stage == STAGES) e_m[m_chan] = 1'b1;
         end else if (m_t < m_drain + SETTLE) begin
            e_sw = exp_codes(m_chan, m_stage, m_port, 1'b0);
         end else if (m_t == m_drain + SETTLE + 1) begin
            e_done = 1'b1;
            e_err  = m_aborted;
         end
      end
      check("sw_sel",    64'(sw_sel),    64'(e_sw));
      check("merge_sel", 64'(merge_sel), 64'(e_m));
      check("busy",      64'(busy),      64'(e_busy));
      check("done",      64'(done),      64'(e_done));
      check("err",       64'(err),       64'(e_err));
      check("req_ready", 64'(req_ready), 64'(rst_n & m_ready_reg));
      if (done === 1'b1 && exp_q.size() > 0) check("latency", 64'(cyc - m_acc_cyc), 64'(exp_q.pop_front()));
      last_done = (done === 1'b1);
      @(posedge clk);
      model_edge();
      cyc++;
      #1;
   endtask

   task automatic request(input int chan, input int stage, input bit port, input int dwell);
      req_chan  = CHAN_W'(chan);
      req_stage = STAGE_W'(stage);
      req_port  = port;
      req_dwell = DWELL_W'(dwell);
      req_valid = 1'b1;
      step();
      req_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while (m_active && n < budget) begin
         step();
         n++;
      end
      if (m_active) check("idle_timeout", 64'(1), 64'(0));
      step();
   endtask

   initial begin
      int n;
      rst_n     = 1'b0;
      abort_drv = 1'b0;
      req_valid = 1'b0;
      req_chan  = '0;
      req_stage = '0;
      req_port  = 1'b0;
      req_dwell = '0;
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // chain 0 to devB at switch 3, dwell 5
      request(0, 3, 1'b1, 5);
      check("sw_route3", 64'(sw_sel), 64'h0BF);
      n = 1;
      while (!last_done && n <= 100) begin
         step();
         if (!last_done) n++;
      end
      check("lat_route3", 64'(n), 64'(15));
      wait_idle(50);

      // chain 1 straight to the merge
      request(1, 9, 1'b0, 1);
      check("sw_merge", 64'(sw_sel), 64'hFFFFC0000);
      check("merge_on", 64'(merge_sel), 64'(2'b10));
      wait_idle(50);

      // out-of-range stage is rejected
      request(0, 10, 1'b0, 3);
      check("err_reject", 64'(err), 64'(1));
      check("sw_reject",  64'(sw_sel), 64'(0));
      step();

      // zero dwell, with extra requests while busy
      request(0, 2, 1'b0, 0);
      req_valid = 1'b1;
      req_stage = STAGE_W'(12);
      repeat (4) step();
      req_valid = 1'b0;
      wait_idle(50);

      // reset in the middle of DWELL
      request(1, 5, 1'b0, 20);
      repeat (6) step();
      rst_n = 1'b0;
      step();
      check("rst_sw",    64'(sw_sel),    64'(0));
      check("rst_merge", 64'(merge_sel), 64'(0));
      check("rst_busy",  64'(busy),      64'(0));
      rst_n = 1'b1;
      step();
      check("rst_ready", 64'(req_ready), 64'(1));

      // random traffic, including bad stages and requests while busy
      for (int i = 0; i < 2000; i++) begin
         req_valid = ($urandom_range(0, 3) == 0);
         req_chan  = CHAN_W'($urandom_range(0, CHANNELS - 1));
         req_stage = STAGE_W'($urandom_range(0, STAGES + 2));
         req_port  = 1'($urandom_range(0, 1));
         req_dwell = DWELL_W'($urandom_range(0, 8));
`ifdef FLOW_ROUTE_ABORT_EN
         abort_drv = ($urandom_range(0, 15) == 0);
`endif
         step();
      end
      req_valid = 1'b0;
      abort_drv = 1'b0;
      wait_idle(100);

`ifdef FLOW_ROUTE_ABORT_EN
      // abort in the second DWELL cycle of a long dwell
      request(0, 3, 1'b0, 100);
      repeat (5) step();
      abort_drv = 1'b1;
      step();
      abort_drv = 1'b0;
      wait_idle(50);
`endif

      // largest dwell value runs to completion
      request(0, 4, 1'b1, (1 << DWELL_W) - 1);
      wait_idle(70000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/flow_route_sequencer.md
FLOW_ROUTE_SEQUENCER -- requirements
Module: flow_route_sequencer

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent source chains.
REQ-002 SHALL have parameter STAGES, default 9: number of junction4 switches per chain.
REQ-003 SHALL have parameter DWELL_W, default 16: width of the dwell counter.
REQ-004 SHALL have parameter SETTLE, default 4: valve settle cycles, range 1..15.
REQ-005 clk  input  1  single clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 req_valid  input  1  route request valid.
REQ-008 req_ready  output  1  sequencer can accept a request.
REQ-009 req_chan  input  clog2(CHANNELS) (min 1)  chain selected for the route.
REQ-010 req_stage  input  clog2(STAGES+1)  target switch index, 0..STAGES-1; value STAGES means route to merge.
REQ-011 req_port  input  1  device branch at target switch: 0=devA (port3), 1=devB (port0).
REQ-012 req_dwell  input  DWELL_W  flow-hold cycles.
REQ-013 sw_sel  output  2*CHANNELS*STAGES  per-switch code; switch s of chain c at bits [2*(c*STAGES+s)+:2]: 00 closed, 01 devA, 10 devB, 11 pass downstream.
REQ-014 merge_sel  output  CHANNELS  one-hot junction3 inlet enable; all-zero means closed.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when a route completes.
REQ-017 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-018 States: IDLE, PRIME, DWELL, DRAIN, DONE. Encoding is free.
REQ-019 req_ready SHALL be 1 only in IDLE. A request is accepted on a cycle where req_valid and req_ready are both 1.
REQ-020 An accepted request with req_chan>=CHANNELS or req_stage>STAGES SHALL pulse err in the next cycle, stay in IDLE and change no outputs.
REQ-021 A valid accept SHALL latch chan, stage, port and dwell, and go to PRIME.
- A latched dwell of 0 is treated as 1.
REQ-022 PRIME: from the cycle after the accept, chain chan SHALL drive the following codes; every other switch stays 00.
- Switches 0..stage-1 drive 11.
- Target switch drives 01 (port=0) or 10 (port=1).
- If stage==STAGES, all switches of the chain drive 11 and merge_sel[chan]=1; otherwise merge_sel=0.
REQ-023 PRIME SHALL last exactly SETTLE cycles, then go to DWELL.
REQ-024 DWELL SHALL hold the valve outputs for exactly the latched dwell cycles, then go to DRAIN.
REQ-025 DRAIN: the target switch and merge_sel SHALL be set to closed (00/0) on entry. Upstream pass switches stay 11 for SETTLE cycles, then all switches are 00. Then go to DONE.
REQ-026 DONE SHALL last one cycle with done=1, then return to IDLE.
- Minimum accept-to-accept time: 2*SETTLE+dwell+3 cycles.
REQ-027 The dwell counter SHALL saturate and never wrap. Dwell = 2^DWELL_W-1 SHALL be honoured exactly.
REQ-028 Any req_valid while busy SHALL be ignored (not queued) and SHALL NOT pulse err.
REQ-029 At most one switch per chain SHALL ever show 01 or 10. At most one merge_sel bit SHALL ever be 1.

Reset
REQ-030 While rst_n=0 at a clock edge, on that edge the block SHALL enter IDLE and set the following; this applies mid-route too:
- sw_sel=0, merge_sel=0
- busy=0, done=0, err=0
- counters cleared
REQ-031 req_ready SHALL be 0 while rst_n=0 and 1 from the first edge after rst_n returns to 1.

Configuration
REQ-032 With macro FLOW_ROUTE_ABORT_EN defined:
- The block SHALL add input abort (1 bit).
- abort=1 in PRIME or DWELL SHALL jump to DRAIN on the next edge.
- done SHALL still pulse at the end of DRAIN, and err SHALL pulse on the same cycle as that done.
REQ-033 Without FLOW_ROUTE_ABORT_EN, the abort port SHALL NOT exist and routes always run to completion.

Verification
REQ-034 Defaults; request chan=0, stage=3, port=1, dwell=5.
- Expect chain 0 switches 0..2 = 11, switch 3 = 10, all else 00.
- Expect done 4+5+4+2 cycles after the accept.
REQ-035 Request chan=1, stage=9, dwell=1.
- Expect all chain-1 switches = 11 and merge_sel=2'b10 during PRIME/DWELL.
- Expect merge_sel=0 at DRAIN entry.
REQ-036 Request chan=2 (CHANNELS=2), or stage=10.
- Expect an err pulse one cycle later, sw_sel unchanged, req_ready=1.
REQ-037 Request with dwell=0.
- Expect a DWELL length of 1 cycle.
- Expect a second req_valid during busy to be ignored, with no err.
REQ-038 Assert rst_n=0 in mid-DWELL of a stage=5 route.
- Expect sw_sel=0, merge_sel=0, busy=0 on the next edge.
- Expect req_ready=1 one cycle after release.
REQ-039 FLOW_ROUTE_ABORT_EN defined; assert abort at DWELL cycle 2 of dwell=100.
- Expect DRAIN next edge, then done and err pulsing together SETTLE+1 cycles later.
